// File: rtl/exec_recovery_ctrl.sv
// Branch-misprediction recovery sequencer: latches the oldest mispredicting
// control-pipe result and drives squash, fetch redirect and rename-restore wait.
module exec_recovery_ctrl #(
  parameter int NUM_CTRL = 2,
  parameter int AL_LOG   = 7,
  parameter int PC_W     = 32,
  parameter int CTI_LOG  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CTRL-1:0]         ctrlValid_i,
  input  logic [NUM_CTRL-1:0]         ctrlMispredict_i,
  input  logic [NUM_CTRL*AL_LOG-1:0]  ctrlAlID_i,
  input  logic [NUM_CTRL*PC_W-1:0]    ctrlNextPC_i,
  input  logic [NUM_CTRL*CTI_LOG-1:0] ctrlCtiID_i,
  input  logic [AL_LOG-1:0]           alHead_i,
  input  logic                        exceptionFlush_i,
  input  logic                        fetchRdy_i,
  input  logic                        restoreDone_i,
  output logic                        squash_o,
  output logic                        redirectValid_o,
  output logic [PC_W-1:0]             redirectPC_o,
  output logic [AL_LOG-1:0]           recoverAlID_o,
  output logic [CTI_LOG-1:0]          recoverCtiID_o,
  output logic                        stallIssue_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQUASH,
    S_REDIRECT,
    S_RESTORE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [AL_LOG-1:0]    r_alID;
  logic [CTI_LOG-1:0]   r_ctiID;
  logic [PC_W-1:0]      r_pc;

  logic [AL_LOG-1:0]    w_age [NUM_CTRL];
  logic [NUM_CTRL-1:0]  w_cand;
  logic                 w_candValid;
  logic [AL_LOG-1:0]    w_candAge;
  logic [AL_LOG-1:0]    w_candAl;
  logic [CTI_LOG-1:0]   w_candCti;
  logic [PC_W-1:0]      w_candPc;
  logic [AL_LOG-1:0]    w_heldAge;
  logic                 w_capture;

  // Ages wrap modulo the active-list size, so distance from the head orders them.
  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_age
    assign w_age[k]  = ctrlAlID_i[k*AL_LOG +: AL_LOG] - alHead_i;
    assign w_cand[k] = ctrlValid_i[k] & ctrlMispredict_i[k];
  end

  always_comb begin
    w_candValid = 1'b0;
    w_candAge   = '0;
    w_candAl    = '0;
    w_candCti   = '0;
    w_candPc    = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (w_cand[k] && (!w_candValid || (w_age[k] < w_candAge))) begin
        w_candValid = 1'b1;
        w_candAge   = w_age[k];
        w_candAl    = ctrlAlID_i[k*AL_LOG +: AL_LOG];
        w_candCti   = ctrlCtiID_i[k*CTI_LOG +: CTI_LOG];
        w_candPc    = ctrlNextPC_i[k*PC_W +: PC_W];
      end
    end
  end

  // Held age is re-derived each cycle so a retiring head never skews the compare.
  assign w_heldAge = r_alID - alHead_i;
  assign w_capture = w_candValid && ((r_state == S_IDLE) || (w_candAge < w_heldAge));

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:     w_nextState = S_IDLE;
      S_SQUASH:   w_nextState = S_REDIRECT;
      S_REDIRECT: if (fetchRdy_i) w_nextState = S_RESTORE;
      S_RESTORE:  if (restoreDone_i) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
    if (exceptionFlush_i) begin
      w_nextState = S_IDLE;
    end else if (w_capture) begin
      w_nextState = S_SQUASH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alID  <= '0;
      r_ctiID <= '0;
      r_pc    <= '0;
    end else if (exceptionFlush_i) begin
      r_alID  <= '0;
      r_ctiID <= '0;
      r_pc    <= '0;
    end else if (w_capture) begin
      r_alID  <= w_candAl;
      r_ctiID <= w_candCti;
      r_pc    <= w_candPc;
    end
  end

  assign squash_o        = (r_state == S_SQUASH);
  assign redirectValid_o = (r_state == S_REDIRECT);
  assign busy_o          = (r_state != S_IDLE);
  assign stallIssue_o    = busy_o;
  assign redirectPC_o    = r_pc;
  assign recoverAlID_o   = r_alID;
  assign recoverCtiID_o  = r_ctiID;

endmodule

// File: tb/tb_exec_recovery_ctrl.sv
// Scenario-driven bench for exec_recovery_ctrl; captured branches are queued
// as expectations and popped when the squash pulse announces them.
module tb_exec_recovery_ctrl;

  localparam int NUM_CTRL = 2;
  localparam int AL_LOG   = 7;
  localparam int PC_W     = 32;
  localparam int CTI_LOG  = 4;

  typedef struct {
    logic [AL_LOG-1:0]  al;
    logic [CTI_LOG-1:0] cti;
    logic [PC_W-1:0]    pc;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [NUM_CTRL-1:0]         ctrlValid = '0;
  logic [NUM_CTRL-1:0]         ctrlMisp = '0;
  logic [NUM_CTRL*AL_LOG-1:0]  ctrlAlID = '0;
  logic [NUM_CTRL*PC_W-1:0]    ctrlPC = '0;
  logic [NUM_CTRL*CTI_LOG-1:0] ctrlCti = '0;
  logic [AL_LOG-1:0]           alHead = '0;
  logic                        exceptionFlush = 1'b0;
  logic                        fetchRdy = 1'b0;
  logic                        restoreDone = 1'b0;
  logic                        squash_o;
  logic                        redirectValid_o;
  logic [PC_W-1:0]             redirectPC_o;
  logic [AL_LOG-1:0]           recoverAlID_o;
  logic [CTI_LOG-1:0]          recoverCtiID_o;
  logic                        stallIssue_o;
  logic                        busy_o;

  exp_t expQ[$];
  exp_t e;
  bit   got;
  int   checks = 0;
  int   passes = 0;

  exec_recovery_ctrl #(
    .NUM_CTRL(NUM_CTRL), .AL_LOG(AL_LOG), .PC_W(PC_W), .CTI_LOG(CTI_LOG)
  ) dut (
    .clk(clk), .reset(reset),
    .ctrlValid_i(ctrlValid), .ctrlMispredict_i(ctrlMisp),
    .ctrlAlID_i(ctrlAlID), .ctrlNextPC_i(ctrlPC), .ctrlCtiID_i(ctrlCti),
    .alHead_i(alHead), .exceptionFlush_i(exceptionFlush),
    .fetchRdy_i(fetchRdy), .restoreDone_i(restoreDone),
    .squash_o(squash_o), .redirectValid_o(redirectValid_o),
    .redirectPC_o(redirectPC_o), .recoverAlID_o(recoverAlID_o),
    .recoverCtiID_o(recoverCtiID_o), .stallIssue_o(stallIssue_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPipe(input int k, input logic [AL_LOG-1:0] al,
                         input logic [PC_W-1:0] pc, input logic [CTI_LOG-1:0] cti);
    ctrlValid[k] = 1'b1;
    ctrlMisp[k]  = 1'b1;
    ctrlAlID[k*AL_LOG +: AL_LOG]   = al;
    ctrlPC[k*PC_W +: PC_W]         = pc;
    ctrlCti[k*CTI_LOG +: CTI_LOG]  = cti;
  endtask

  task automatic clearPipes();
    ctrlValid = '0;
    ctrlMisp  = '0;
  endtask

  task automatic pushExp(input logic [AL_LOG-1:0] al, input logic [CTI_LOG-1:0] cti,
                         input logic [PC_W-1:0] pc);
    exp_t x;
    x.al = al; x.cti = cti; x.pc = pc;
    expQ.push_back(x);
  endtask

  task automatic popExp(output exp_t x, output bit ok);
    ok = (expQ.size() != 0);
    x.al = '0; x.cti = '0; x.pc = '0;
    if (ok) x = expQ.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({squash_o, redirectValid_o, stallIssue_o, busy_o, redirectPC_o, recoverAlID_o, recoverCtiID_o} !== '0)
      $display("FAIL reset_outputs: got sq=%b rv=%b st=%b bsy=%b pc=%h al=%0d cti=%0d expected all 0",
               squash_o, redirectValid_o, stallIssue_o, busy_o, redirectPC_o, recoverAlID_o, recoverCtiID_o);
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_idle: busy got %b expected 0", busy_o);
    else passes++;
  endtask

  task automatic test_single();
    alHead = 0; fetchRdy = 1'b1; restoreDone = 1'b1;
    setPipe(0, 7'd5, 32'h1000, 4'd3);
    pushExp(7'd5, 4'd3, 32'h1000);
    tick();
    clearPipes();
    checks++;
    if (squash_o !== 1'b1 || redirectValid_o !== 1'b0)
      $display("FAIL single_t1: sq=%b rv=%b expected sq=1 rv=0", squash_o, redirectValid_o);
    else passes++;
    popExp(e, got);
    checks++;
    if (!got || recoverAlID_o !== e.al || recoverCtiID_o !== e.cti)
      $display("FAIL single_ids: al=%0d cti=%0d expected al=%0d cti=%0d (queued=%b)",
               recoverAlID_o, recoverCtiID_o, e.al, e.cti, got);
    else passes++;
    tick();
    checks++;
    if (squash_o !== 1'b0 || redirectValid_o !== 1'b1 || redirectPC_o !== e.pc)
      $display("FAIL single_t2: sq=%b rv=%b pc=%h expected sq=0 rv=1 pc=%h",
               squash_o, redirectValid_o, redirectPC_o, e.pc);
    else passes++;
    tick();
    checks++;
    if (redirectValid_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL single_t3: rv=%b busy=%b expected rv=0 busy=1", redirectValid_o, busy_o);
    else passes++;
    tick();
    checks++;
    if (busy_o !== 1'b0 || stallIssue_o !== 1'b0)
      $display("FAIL single_t4: busy=%b stall=%b expected 0", busy_o, stallIssue_o);
    else passes++;
  endtask

  task automatic test_wrap_age();
    alHead = 7'd120;
    setPipe(0, 7'd3, 32'h2000, 4'd1);
    setPipe(1, 7'd125, 32'h3000, 4'd2);
    pushExp(7'd125, 4'd2, 32'h3000);
    tick();
    clearPipes();
    popExp(e, got);
    checks++;
    if (!got || squash_o !== 1'b1 || recoverAlID_o !== e.al || redirectPC_o !== e.pc || recoverCtiID_o !== e.cti)
      $display("FAIL wrap_pick: sq=%b al=%0d pc=%h cti=%0d expected sq=1 al=%0d pc=%h cti=%0d",
               squash_o, recoverAlID_o, redirectPC_o, recoverCtiID_o, e.al, e.pc, e.cti);
    else passes++;
    for (int i = 0; i < 10 && busy_o; i++) tick();
    checks++;
    if (busy_o !== 1'b0) $display("FAIL wrap_drain: busy=%b expected 0 within 10 cycles", busy_o);
    else passes++;
  endtask

  task automatic test_older_replace();
    fetchRdy = 1'b0; restoreDone = 1'b0; alHead = 7'd10;
    setPipe(0, 7'd40, 32'h4000, 4'd4);
    pushExp(7'd40, 4'd4, 32'h4000);
    tick();
    clearPipes();
    popExp(e, got);
    checks++;
    if (!got || squash_o !== 1'b1 || recoverAlID_o !== e.al)
      $display("FAIL replace_first: sq=%b al=%0d expected sq=1 al=%0d", squash_o, recoverAlID_o, e.al);
    else passes++;
    tick();
    checks++;
    if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h4000)
      $display("FAIL replace_redir: rv=%b pc=%h expected rv=1 pc=4000", redirectValid_o, redirectPC_o);
    else passes++;
    tick();
    setPipe(1, 7'd20, 32'h5000, 4'd5);
    pushExp(7'd20, 4'd5, 32'h5000);
    tick();
    clearPipes();
    popExp(e, got);
    checks++;
    if (!got || squash_o !== 1'b1 || redirectValid_o !== 1'b0 || recoverAlID_o !== e.al ||
        redirectPC_o !== e.pc || recoverCtiID_o !== e.cti)
      $display("FAIL replace_second: sq=%b rv=%b al=%0d pc=%h cti=%0d expected sq=1 rv=0 al=%0d pc=%h cti=%0d",
               squash_o, redirectValid_o, recoverAlID_o, redirectPC_o, recoverCtiID_o, e.al, e.pc, e.cti);
    else passes++;
    tick();
    checks++;
    if (squash_o !== 1'b0 || redirectValid_o !== 1'b1)
      $display("FAIL replace_oneshot: sq=%b rv=%b expected sq=0 rv=1", squash_o, redirectValid_o);
    else passes++;
    setPipe(0, 7'd30, 32'h6000, 4'd6);
    tick();
    clearPipes();
    checks++;
    if (squash_o !== 1'b0 || redirectValid_o !== 1'b1 || recoverAlID_o !== 7'd20 || redirectPC_o !== 32'h5000)
      $display("FAIL replace_younger: sq=%b rv=%b al=%0d pc=%h expected sq=0 rv=1 al=20 pc=5000",
               squash_o, redirectValid_o, recoverAlID_o, redirectPC_o);
    else passes++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h5000)
        $display("FAIL backpressure_hold%0d: rv=%b pc=%h expected rv=1 pc=5000", i, redirectValid_o, redirectPC_o);
      else passes++;
    end
    fetchRdy = 1'b1;
    tick();
    fetchRdy = 1'b0;
    checks++;
    if (redirectValid_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL backpressure_advance: rv=%b busy=%b expected rv=0 busy=1", redirectValid_o, busy_o);
    else passes++;
    tick();
    checks++;
    if (busy_o !== 1'b1 || squash_o !== 1'b0)
      $display("FAIL restore_wait: busy=%b sq=%b expected busy=1 sq=0", busy_o, squash_o);
    else passes++;
  endtask

  task automatic test_exception_flush();
    setPipe(0, 7'd12, 32'h7000, 4'd9);
    exceptionFlush = 1'b1;
    tick();
    clearPipes();
    exceptionFlush = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || squash_o !== 1'b0 || redirectValid_o !== 1'b0)
      $display("FAIL flush_idle: busy=%b sq=%b rv=%b expected all 0", busy_o, squash_o, redirectValid_o);
    else passes++;
    tick();
    checks++;
    if (busy_o !== 1'b0 || squash_o !== 1'b0)
      $display("FAIL flush_discard: busy=%b sq=%b expected 0", busy_o, squash_o);
    else passes++;
  endtask

  task automatic test_reset_mid();
    alHead = 0; fetchRdy = 1'b0; restoreDone = 1'b0;
    setPipe(0, 7'd9, 32'h8000, 4'd7);
    pushExp(7'd9, 4'd7, 32'h8000);
    tick();
    clearPipes();
    popExp(e, got);
    checks++;
    if (!got || squash_o !== 1'b1 || recoverAlID_o !== e.al)
      $display("FAIL rstmid_capture: sq=%b al=%0d expected sq=1 al=%0d", squash_o, recoverAlID_o, e.al);
    else passes++;
    tick();
    checks++;
    if (redirectValid_o !== 1'b1) $display("FAIL rstmid_redirect: rv=%b expected 1", redirectValid_o);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({squash_o, redirectValid_o, stallIssue_o, busy_o, redirectPC_o, recoverAlID_o, recoverCtiID_o} !== '0)
      $display("FAIL rstmid_async: sq=%b rv=%b bsy=%b pc=%h al=%0d expected all 0",
               squash_o, redirectValid_o, busy_o, redirectPC_o, recoverAlID_o);
    else passes++;
    tick();
    reset = 1'b0;
    ctrlValid[1] = 1'b1;
    ctrlAlID[AL_LOG +: AL_LOG] = 7'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy_o !== 1'b0 || squash_o !== 1'b0)
        $display("FAIL rstmid_quiet%0d: busy=%b sq=%b expected 0", i, busy_o, squash_o);
      else passes++;
    end
    clearPipes();
    setPipe(1, 7'd2, 32'h9000, 4'd8);
    pushExp(7'd2, 4'd8, 32'h9000);
    tick();
    clearPipes();
    popExp(e, got);
    checks++;
    if (!got || squash_o !== 1'b1 || recoverAlID_o !== e.al || redirectPC_o !== e.pc)
      $display("FAIL rstmid_new: sq=%b al=%0d pc=%h expected sq=1 al=%0d pc=%h",
               squash_o, recoverAlID_o, redirectPC_o, e.al, e.pc);
    else passes++;
    fetchRdy = 1'b1; restoreDone = 1'b1;
    for (int i = 0; i < 10 && busy_o; i++) tick();
    checks++;
    if (busy_o !== 1'b0) $display("FAIL rstmid_drain: busy=%b expected 0 within 10 cycles", busy_o);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_age();
    test_older_replace();
    test_backpressure();
    test_exception_flush();
    test_reset_mid();
    checks++;
    if (expQ.size() != 0) $display("FAIL scoreboard_empty: %0d left expected 0", expQ.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
